inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Fetch-side initiator for the combinational instruction memory. Owns the PC,
//  drives the fetch address and captures the returned word into the IF/ID
//  pipeline register for decode. Handles stall, flush and branch/jump redirect,
//  with an optional interrupt redirect.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset; first fetch address after release
//  EXC_VECTOR  32'h8000_0004  interrupt target (used only with INST_FETCH_EXC_EN)
//  NOP_INST    32'h0000_0000  instruction word inserted as a bubble
// PORTS
//  clk            in   1   system clock, all state on rising edge
//  reset          in   1   asynchronous, active-low reset
//  imem_addr      out  32  fetch address to instruction memory (= pc, combinational)
//  imem_inst      in   32  instruction word returned same cycle for imem_addr
//  stall          in   1   decode not ready: hold pc and IF/ID
//  flush          in   1   load bubble into IF/ID this cycle
//  jump           in   1   redirect to jump_target (resolved in ID)
//  jump_target    in   32  jump destination
//  branch_taken   in   1   redirect to branch_target (resolved in EX)
//  branch_target  in   32  branch destination
//  irq            in   1   interrupt request (only with INST_FETCH_EXC_EN)
//  if_inst        out  32  IF/ID instruction
//  if_pc          out  32  IF/ID PC of if_inst
//  if_pc_plus4    out  32  IF/ID if_pc + 4
//  if_valid       out  1   IF/ID holds a real instruction (0 = bubble)
//  epc            out  32  PC saved on interrupt (only with INST_FETCH_EXC_EN)
// BEHAVIOUR
//  - Reset (reset=0, async): pc=RESET_PC; if_inst=NOP_INST; if_pc=0;
//    if_pc_plus4=0; if_valid=0; epc=0. imem_addr=RESET_PC while in reset.
//  - Latency: word at pc appears on if_inst one rising edge after the cycle in
//    which imem_addr=pc, if not stalled or redirected.
//  - Next-pc priority, highest first: irq > jump > branch_taken > stall > pc+4.
//  - Redirect (irq/jump/branch_taken): pc <= target with bits[1:0] forced to 0;
//    IF/ID <= bubble (if_inst=NOP_INST, if_valid=0, if_pc/if_pc_plus4 hold).
//    Redirect overrides stall and flush in the same cycle.
//    jump and branch_taken together: jump wins.
//  - Stall (no redirect): pc and all IF/ID outputs hold.
//    stall overrides flush; flush is lost unless still asserted.
//  - Flush (no redirect, no stall): IF/ID <= bubble; pc <= pc+4.
//  - Normal: IF/ID <= {imem_inst, pc, pc+4}, if_valid=1; pc <= pc+4.
//  - Arithmetic is 32-bit modulo 2^32: pc=32'hFFFF_FFFC advances to 0,
//    if_pc_plus4=0.
//  - pc[1:0] is always 0. RESET_PC must be word aligned.
//  - Reset asserted mid-stall or mid-redirect: all state returns to reset values
//    immediately; pending redirect is discarded.
// CONFIGURATION
//  INST_FETCH_EXC_EN defined:
//    - irq is sampled each edge; irq=1 redirects pc to EXC_VECTOR.
//    - epc <= if_valid ? if_pc : pc, i.e. the oldest instruction not yet decoded.
//    - epc is otherwise held.
//  INST_FETCH_EXC_EN undefined:
//    - irq port is present but ignored; epc is tied to 32'h0.
//    - No EXC_VECTOR logic.
// TESTING
//  1. Release reset, imem returns 32'h1111_0000+addr, no stall
//     -> imem_addr 0,4,8,...; if_valid=1 from 1st edge, if_pc lags imem_addr by 1 cycle.
//  2. stall=1 for 3 cycles at pc=8 -> imem_addr stays 8, if_pc stays 4, if_inst unchanged.
//     On release: if_pc=8 next edge.
//  3. branch_taken=1, branch_target=32'h0000_0103, plus stall=1
//     -> pc=32'h100 next edge, if_valid=0, if_inst=NOP_INST.
//     Fetch resumes at 0x100, 0x104.
//  4. jump (target 0x40) and branch_taken (target 0x80) in the same cycle
//     -> pc=0x40, one bubble.
//  5. Force pc to 32'hFFFF_FFFC via jump -> next pc=0, if_pc_plus4=0.
//     Assert reset mid-run -> all outputs at reset values without a clock edge.
//  6. INST_FETCH_EXC_EN: irq=1 with if_pc=0x20, if_valid=1
//     -> pc=32'h8000_0004, epc=0x20, if_valid=0.
//     Without the macro: irq is ignored and epc stays 0.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
// Instruction memory fetch bus: address out, word back the same cycle.
// master = fetch unit, slave = memory (imem_addr, imem_inst).
interface inst_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;

  modport master (
    output imem_addr,
    input  imem_inst
  );

  modport slave (
    input  imem_addr,
    output imem_inst
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, drives imem, fills IF/ID; stall/flush/redirect.
// Ports: clk, reset (async low), imem bus, control in, IF/ID + epc out.
// Define INST_FETCH_EXC_EN to enable irq redirect to EXC_VECTOR and epc.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0004,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  inst_fetch_unit_if.master         imem,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      jump,
  input  logic [31:0]               jump_target,
  input  logic                      branch_taken,
  input  logic [31:0]               branch_target,
  input  logic                      irq,
  output logic [31:0]               if_inst,
  output logic [31:0]               if_pc,
  output logic [31:0]               if_pc_plus4,
  output logic                      if_valid,
  output logic [31:0]               epc
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifp4_q, ifp4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] tgt;
  logic        irq_hit;
  logic        redir;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef INST_FETCH_EXC_EN
  assign irq_hit = irq;
`else
  assign irq_hit = 1'b0;
`endif

  assign redir = irq_hit | jump | branch_taken;

  always_comb begin
    tgt = branch_target;
    if (irq_hit) begin
`ifdef INST_FETCH_EXC_EN
      tgt = EXC_VECTOR;
`endif
    end else if (jump) begin
      tgt = jump_target;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    ifpc_d  = ifpc_q;
    ifp4_d  = ifp4_q;
    valid_d = valid_q;
    if (redir) begin
      pc_d    = {tgt[31:2], 2'b00};
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (stall) begin
      pc_d    = pc_q;
    end else if (flush) begin
      pc_d    = pc_plus4;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      inst_d  = imem.imem_inst;
      ifpc_d  = pc_q;
      ifp4_d  = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      ifpc_q  <= 32'h0;
      ifp4_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ifpc_q  <= ifpc_d;
      ifp4_q  <= ifp4_d;
      valid_q <= valid_d;
    end
  end

`ifdef INST_FETCH_EXC_EN
  logic [31:0] epc_q, epc_d;

  // Oldest undecoded instruction: the one in IF/ID, else the one being fetched.
  always_comb begin
    epc_d = epc_q;
    if (irq_hit) begin
      epc_d = valid_q ? ifpc_q : pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_q <= 32'h0;
    end else begin
      epc_q <= epc_d;
    end
  end

  assign epc = epc_q;

  logic unused_ok;
  assign unused_ok = ^{jump_target[1:0], branch_target[1:0]};
`else
  assign epc = 32'h0;

  logic unused_ok;
  assign unused_ok = ^{irq, EXC_VECTOR,
                       jump_target[1:0], branch_target[1:0]};
`endif

  assign imem.imem_addr = pc_q;
  assign if_inst        = inst_q;
  assign if_pc          = ifpc_q;
  assign if_pc_plus4    = ifp4_q;
  assign if_valid       = valid_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus
// randomized control traffic against a transaction-level model.
module tb_inst_fetch_unit;

  localparam logic [31:0] EXC = 32'h8000_0004;
  localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef INST_FETCH_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        stall, flush, jump, branch_taken, irq;
  logic [31:0] jump_target, branch_target;
  logic [31:0] if_inst, if_pc, if_pc_plus4, epc;
  logic        if_valid;

  int n_checks;
  int n_err;

  // model state
  logic [31:0] m_pc, m_inst, m_ifpc, m_p4, m_epc;
  logic        m_valid;

  inst_fetch_unit_if imem_if ();

  assign imem_if.imem_inst = 32'h1111_0000 + imem_if.imem_addr;

  inst_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (imem_if.master),
    .stall         (stall),
    .flush         (flush),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .irq           (irq),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc_plus4),
    .if_valid      (if_valid),
    .epc           (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc    = 32'h0;
    m_inst  = NOP;
    m_ifpc  = 32'h0;
    m_p4    = 32'h0;
    m_valid = 1'b0;
    m_epc   = 32'h0;
  endtask

  task automatic clr_in();
    stall = 0; flush = 0; jump = 0;
    branch_taken = 0; irq = 0;
    jump_target = 0; branch_target = 0;
  endtask

  // Advance one cycle: model applies the priority rules, DUT sees an edge.
  task automatic tick();
    logic [31:0] t;
    bit take_irq;
    take_irq = EXC_EN && irq;
    if (take_irq) m_epc = m_valid ? m_ifpc : m_pc;
    if (take_irq || jump || branch_taken) begin
      t = take_irq ? EXC : (jump ? jump_target : branch_target);
      m_pc = t & ~32'd3;
      m_inst = NOP;
      m_valid = 0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (flush) begin
      m_pc = m_pc + 4;
      m_inst = NOP;
      m_valid = 0;
    end else begin
      m_inst = 32'h1111_0000 + m_pc;
      m_ifpc = m_pc;
      m_p4 = m_pc + 4;
      m_valid = 1;
      m_pc = m_pc + 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_in();
    reset = 0;
    model_reset();
    #2;
    n_checks++;
    if ({imem_if.imem_addr, if_inst, if_pc, if_pc_plus4,
         if_valid, epc} !== {32'h0, NOP, 64'h0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset: addr=%h inst=%h pc=%h p4=%h v=%b epc=%h",
               imem_if.imem_addr, if_inst, if_pc, if_pc_plus4,
               if_valid, epc);
    end
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({imem_if.imem_addr, if_inst, if_pc, if_pc_plus4, if_valid}
          !== {m_pc, m_inst, m_ifpc, m_p4, m_valid}) begin
        n_err++;
        $display("FAIL seq%0d: addr=%h inst=%h pc=%h v=%b exp %h %h %h %b",
                 i, imem_if.imem_addr, if_inst, if_pc, if_valid,
                 m_pc, m_inst, m_ifpc, m_valid);
      end
    end
    n_checks++;
    if (imem_if.imem_addr !== 32'h8 || if_pc !== 32'h4 ||
        if_inst !== 32'h1111_0004 || if_valid !== 1'b1) begin
      n_err++;
      $display("FAIL seq_lag: addr=%h if_pc=%h inst=%h v=%b exp 8 4",
               imem_if.imem_addr, if_pc, if_inst, if_valid);
    end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (imem_if.imem_addr !== 32'h8 || if_pc !== 32'h4 ||
          if_inst !== 32'h1111_0004) begin
        n_err++;
        $display("FAIL stall%0d: addr=%h if_pc=%h inst=%h exp 8 4",
                 i, imem_if.imem_addr, if_pc, if_inst);
      end
    end
    stall = 0;
    tick();
    n_checks++;
    if (if_pc !== 32'h8 || imem_if.imem_addr !== 32'hC) begin
      n_err++;
      $display("FAIL stall_release: if_pc=%h addr=%h exp 8 c",
               if_pc, imem_if.imem_addr);
    end
  endtask

  task automatic test_branch_stall();
    branch_taken = 1;
    branch_target = 32'h0000_0103;
    stall = 1;
    flush = 1;
    tick();
    clr_in();
    n_checks++;
    if (imem_if.imem_addr !== 32'h100 || if_valid !== 1'b0 ||
        if_inst !== NOP || if_pc !== m_ifpc) begin
      n_err++;
      $display("FAIL branch: addr=%h v=%b inst=%h if_pc=%h exp 100",
               imem_if.imem_addr, if_valid, if_inst, if_pc);
    end
    tick();
    tick();
    n_checks++;
    if (if_pc !== 32'h104 || imem_if.imem_addr !== 32'h108 ||
        if_inst !== 32'h1111_0104) begin
      n_err++;
      $display("FAIL branch_resume: if_pc=%h addr=%h exp 104 108",
               if_pc, imem_if.imem_addr);
    end
  endtask

  task automatic test_jump_vs_branch();
    jump = 1; jump_target = 32'h40;
    branch_taken = 1; branch_target = 32'h80;
    tick();
    clr_in();
    n_checks++;
    if (imem_if.imem_addr !== 32'h40 || if_valid !== 1'b0) begin
      n_err++;
      $display("FAIL jump_win: addr=%h v=%b exp 40 0",
               imem_if.imem_addr, if_valid);
    end
    tick();
    n_checks++;
    if (if_pc !== 32'h40 || if_valid !== 1'b1) begin
      n_err++;
      $display("FAIL jump_one_bubble: if_pc=%h v=%b exp 40 1",
               if_pc, if_valid);
    end
  endtask

  task automatic test_flush();
    flush = 1;
    tick();
    flush = 0;
    n_checks++;
    if (if_valid !== 1'b0 || if_inst !== NOP ||
        imem_if.imem_addr !== m_pc) begin
      n_err++;
      $display("FAIL flush: v=%b inst=%h addr=%h exp 0 %h %h",
               if_valid, if_inst, imem_if.imem_addr, NOP, m_pc);
    end
  endtask

  task automatic test_wrap();
    jump = 1; jump_target = 32'hFFFF_FFFF;
    tick();
    clr_in();
    n_checks++;
    if (imem_if.imem_addr !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_pc: addr=%h exp fffffffc", imem_if.imem_addr);
    end
    tick();
    n_checks++;
    if (imem_if.imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC ||
        if_pc_plus4 !== 32'h0) begin
      n_err++;
      $display("FAIL wrap: addr=%h if_pc=%h p4=%h exp 0 fffffffc 0",
               imem_if.imem_addr, if_pc, if_pc_plus4);
    end
  endtask

  task automatic test_irq();
    jump = 1; jump_target = 32'h20;
    tick();
    clr_in();
    tick();
    irq = 1;
    stall = 1;
    tick();
    clr_in();
`ifdef INST_FETCH_EXC_EN
    n_checks++;
    if (imem_if.imem_addr !== EXC || epc !== 32'h20 ||
        if_valid !== 1'b0) begin
      n_err++;
      $display("FAIL irq: addr=%h epc=%h v=%b exp %h 20 0",
               imem_if.imem_addr, epc, if_valid, EXC);
    end
`else
    n_checks++;
    if (imem_if.imem_addr !== 32'h24 || epc !== 32'h0 ||
        if_pc !== 32'h20) begin
      n_err++;
      $display("FAIL irq_ignored: addr=%h epc=%h if_pc=%h exp 24 0 20",
               imem_if.imem_addr, epc, if_pc);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(99) < 30);
      flush = ($urandom_range(99) < 15);
      jump = ($urandom_range(99) < 6);
      branch_taken = ($urandom_range(99) < 6);
      irq = ($urandom_range(99) < 4);
      jump_target = $urandom;
      branch_target = $urandom;
      tick();
      n_checks++;
      if ({imem_if.imem_addr, if_inst, if_pc, if_pc_plus4,
           if_valid, epc} !==
          {m_pc, m_inst, m_ifpc, m_p4, m_valid, m_epc}) begin
        n_err++;
        $display("FAIL rand%0d: addr=%h inst=%h pc=%h p4=%h v=%b epc=%h",
                 i, imem_if.imem_addr, if_inst, if_pc, if_pc_plus4,
                 if_valid, epc);
        $display("  exp addr=%h inst=%h pc=%h p4=%h v=%b epc=%h",
                 m_pc, m_inst, m_ifpc, m_p4, m_valid, m_epc);
      end
    end
    clr_in();
  endtask

  task automatic test_async_reset();
    jump = 1; jump_target = 32'h300;
    tick();
    clr_in();
    tick();
    stall = 1;
    jump = 1; jump_target = 32'h500;
    #3;
    reset = 0;
    model_reset();
    #1;
    n_checks++;
    if ({imem_if.imem_addr, if_inst, if_pc, if_pc_plus4,
         if_valid, epc} !== {32'h0, NOP, 64'h0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL async_reset: addr=%h inst=%h pc=%h p4=%h v=%b",
               imem_if.imem_addr, if_inst, if_pc, if_pc_plus4, if_valid);
    end
    @(posedge clk);
    #1;
    clr_in();
    reset = 1;
    tick();
    n_checks++;
    if (if_pc !== 32'h0 || if_valid !== 1'b1 ||
        imem_if.imem_addr !== 32'h4) begin
      n_err++;
      $display("FAIL after_reset: if_pc=%h v=%b addr=%h exp 0 1 4",
               if_pc, if_valid, imem_if.imem_addr);
    end
  endtask

  initial begin
    n_checks = 0;
    n_err = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_stall();
    test_jump_vs_branch();
    test_flush();
    test_wrap();
    test_irq();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
